// File: rtl/seg_ser_ctrl.sv
// -----------------------------------------------------------------------------
// seg_ser_ctrl
// Serialises a DATA_W-bit segment pattern into an external shift register and
// then strobes its storage register. One frame is DATA_W LOW/HIGH ser_clk
// periods of DIV clk cycles per half, followed by a DIV-cycle latch strobe.
//
// Build option:
//   SEG_SER_LSB_FIRST_EN  defined   -> data[0] is sent first
//                         undefined -> data[DATA_W-1] is sent first (default)
//
// Parameters:
//   DATA_W  segment bits per frame (2..256)
//   DIV     clk cycles per ser_clk half-period (1..255)
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   frame request, honoured only while idle
//   data       in   parallel pattern, captured when start is accepted
//   ser_out    out  serial data (registered)
//   ser_clk    out  shift clock; external shifter samples on its rising edge
//   ser_latch  out  storage-register strobe after the last bit
//   busy       out  frame in progress
//   done       out  one-cycle frame-complete pulse
// -----------------------------------------------------------------------------
module seg_ser_ctrl #(
  parameter int DATA_W = 64,
  parameter int DIV    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              ser_out,
  output logic              ser_clk,
  output logic              ser_latch,
  output logic              busy,
  output logic              done
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam int DW = $clog2(DIV + 1);

  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOW   = 2'd1;
  localparam logic [1:0] ST_HIGH  = 2'd2;
  localparam logic [1:0] ST_LATCH = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [DW-1:0]     div_q, div_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] sr_q, sr_d;

  logic ser_out_q, ser_out_d;
  logic ser_clk_q, ser_clk_d;
  logic ser_latch_q, ser_latch_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  // Bit currently presented on the serial line.
  function automatic logic cur_bit(input logic [DATA_W-1:0] sr);
`ifdef SEG_SER_LSB_FIRST_EN
    cur_bit = sr[0];
`else
    cur_bit = sr[DATA_W-1];
`endif
  endfunction

  // Advance the shift register so the next bit to send is in the output slot.
  function automatic logic [DATA_W-1:0] shift_one(input logic [DATA_W-1:0] sr);
`ifdef SEG_SER_LSB_FIRST_EN
    shift_one = {1'b0, sr[DATA_W-1:1]};
`else
    shift_one = {sr[DATA_W-2:0], 1'b0};
`endif
  endfunction

  // Frame sequencer: state, divide counter, bit counter and shift register.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sr_d    = data;
          div_d   = {DW{1'b0}};
          bit_d   = {BW{1'b0}};
          state_d = ST_LOW;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOW: begin
        if (div_q == DIV_LAST) begin
          div_d   = {DW{1'b0}};
          state_d = ST_HIGH;
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      ST_HIGH: begin
        if (div_q == DIV_LAST) begin
          div_d = {DW{1'b0}};
          sr_d  = shift_one(sr_q);
          bit_d = bit_q + BIT_ONE;
          // bit_q counts bits already completed before this one.
          if (bit_q == LAST_BIT) begin
            state_d = ST_LATCH;
          end else begin
            state_d = ST_LOW;
          end
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      ST_LATCH: begin
        if (div_q == DIV_LAST) begin
          div_d   = {DW{1'b0}};
          state_d = ST_IDLE;
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        div_d   = {DW{1'b0}};
        bit_d   = {BW{1'b0}};
        sr_d    = {DATA_W{1'b0}};
      end
    endcase
  end

  // Output next-values derived from the next state so outputs line up with it.
  always_comb begin
    busy_d      = (state_d != ST_IDLE);
    ser_clk_d   = (state_d == ST_HIGH);
    ser_latch_d = (state_d == ST_LATCH);
    done_d      = (state_q == ST_LATCH) && (state_d == ST_IDLE);
    if ((state_d == ST_LOW) || (state_d == ST_HIGH)) begin
      ser_out_d = cur_bit(sr_d);
    end else begin
      ser_out_d = 1'b0;
    end
  end

  // State and output registers; reset aborts any frame silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      div_q       <= {DW{1'b0}};
      bit_q       <= {BW{1'b0}};
      sr_q        <= {DATA_W{1'b0}};
      ser_out_q   <= 1'b0;
      ser_clk_q   <= 1'b0;
      ser_latch_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      sr_q        <= sr_d;
      ser_out_q   <= ser_out_d;
      ser_clk_q   <= ser_clk_d;
      ser_latch_q <= ser_latch_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign ser_out   = ser_out_q;
  assign ser_clk   = ser_clk_q;
  assign ser_latch = ser_latch_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_seg_ser_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_ser_ctrl
// Directed bench for seg_ser_ctrl using three instances:
//   u_a : DATA_W=8,  DIV=4
//   u_b : DATA_W=8,  DIV=1
//   u_c : DATA_W=64, DIV=1
// Expected bit order follows SEG_SER_LSB_FIRST_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_seg_ser_ctrl;

  logic clk;
  logic rst_n;

  logic       start_a, start_b, start_c;
  logic [7:0] data_a, data_b;
  logic [63:0] data_c;

  logic so_a, sc_a, sl_a, bz_a, dn_a;
  logic so_b, sc_b, sl_b, bz_b, dn_b;
  logic so_c, sc_c, sl_c, bz_c, dn_c;

  int sel_v;
  logic o_out, o_clk, o_latch, o_busy, o_done;

  int checks;
  int errors;

  logic [63:0] st_bits;
  int st_cyc, st_busy, st_rises, st_latch, st_done, st_minrun, st_maxrun;
  bit st_reset_hit;

  seg_ser_ctrl #(.DATA_W(8), .DIV(4)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .data(data_a),
    .ser_out(so_a), .ser_clk(sc_a), .ser_latch(sl_a), .busy(bz_a), .done(dn_a)
  );

  seg_ser_ctrl #(.DATA_W(8), .DIV(1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .data(data_b),
    .ser_out(so_b), .ser_clk(sc_b), .ser_latch(sl_b), .busy(bz_b), .done(dn_b)
  );

  seg_ser_ctrl #(.DATA_W(64), .DIV(1)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .data(data_c),
    .ser_out(so_c), .ser_clk(sc_c), .ser_latch(sl_c), .busy(bz_c), .done(dn_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Route the selected instance to the common observation signals.
  always_comb begin
    case (sel_v)
      0:       {o_out, o_clk, o_latch, o_busy, o_done} = {so_a, sc_a, sl_a, bz_a, dn_a};
      1:       {o_out, o_clk, o_latch, o_busy, o_done} = {so_b, sc_b, sl_b, bz_b, dn_b};
      default: {o_out, o_clk, o_latch, o_busy, o_done} = {so_c, sc_c, sl_c, bz_c, dn_c};
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected transmit order, first-sent bit ends up most significant.
  function automatic logic [63:0] ord(input logic [63:0] d, input int w);
    logic [63:0] r;
    r = 64'd0;
`ifdef SEG_SER_LSB_FIRST_EN
    for (int i = 0; i < w; i++) r[w-1-i] = d[i];
`else
    r = d;
`endif
    return r;
  endfunction

  task automatic drive(input int sel, input logic [63:0] d, input logic s);
    case (sel)
      0:       begin data_a = d[7:0]; start_a = s; end
      1:       begin data_b = d[7:0]; start_b = s; end
      default: begin data_c = d;      start_c = s; end
    endcase
  endtask

  task automatic set_start(input int sel, input logic s);
    case (sel)
      0:       start_a = s;
      1:       start_b = s;
      default: start_c = s;
    endcase
  endtask

  task automatic record_run(input int len);
    if (len < st_minrun) st_minrun = len;
    if (len > st_maxrun) st_maxrun = len;
  endtask

  // Launch a frame and observe it until done (bounded). Optional mid-frame
  // start injection and reset at a given ser_clk rise.
  task automatic run(input int sel, input logic [63:0] d, input bit hold,
                     input int inj_cyc, input logic [63:0] inj_d, input int rst_bit);
    bit prev_clk;
    bit stop;
    int run_len;
    st_bits = 64'd0; st_cyc = 0; st_busy = 0; st_rises = 0; st_latch = 0;
    st_done = 0; st_minrun = 1000; st_maxrun = 0; st_reset_hit = 1'b0;
    prev_clk = 1'b0; run_len = 0; stop = 1'b0;
    sel_v = sel;
    drive(sel, d, 1'b1);
    for (int c = 0; c < 400 && !stop; c++) begin
      @(posedge clk); #1;
      if (!hold && c == 0) set_start(sel, 1'b0);
      if (c == inj_cyc) drive(sel, inj_d, 1'b1);
      if (c == inj_cyc + 1) set_start(sel, 1'b0);
      st_cyc++;
      if (o_busy) st_busy++;
      if (o_latch) st_latch++;
      if (o_done) begin st_done++; stop = 1'b1; end
      if (o_clk && !prev_clk) begin
        st_rises++;
        st_bits = {st_bits[62:0], o_out};
      end
      if (o_busy) begin
        if (run_len == 0 || o_clk == prev_clk) run_len++;
        else begin record_run(run_len); run_len = 1; end
      end else if (run_len > 0) begin
        record_run(run_len);
        run_len = 0;
      end
      prev_clk = o_clk;
      if (rst_bit > 0 && st_rises == rst_bit && !st_reset_hit) begin
        st_reset_hit = 1'b1;
        set_start(sel, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_async_outputs", {59'd0, o_out, o_clk, o_latch, o_busy, o_done}, 64'd0);
        stop = 1'b1;
      end
    end
  endtask

  initial begin
    int quiet;
    checks = 0; errors = 0; sel_v = 0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    data_a = 8'h00; data_b = 8'h00; data_c = 64'd0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_a", {59'd0, so_a, sc_a, sl_a, bz_a, dn_a}, 64'd0);
    chk("reset_c", {59'd0, so_c, sc_c, sl_c, bz_c, dn_c}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 64-bit, DIV=1, end bits set.
    run(2, 64'h8000_0000_0000_0001, 1'b0, -1, 64'd0, 0);
    chk("w64_bits",  st_bits, ord(64'h8000_0000_0000_0001, 64));
    chk("w64_rises", 64'(st_rises), 64'd64);
    chk("w64_busy",  64'(st_busy), 64'd129);
    chk("w64_latch", 64'(st_latch), 64'd1);
    chk("w64_done",  64'(st_done), 64'd1);
    chk("w64_cyc",   64'(st_cyc), 64'd130);
    chk("w64_runs",  {32'(st_minrun), 32'(st_maxrun)}, {32'd1, 32'd1});
    @(posedge clk); #1;
    chk("w64_idle_after", {59'd0, so_c, sc_c, sl_c, bz_c, dn_c}, 64'd0);

    // 8-bit, DIV=4, A5.
    run(0, 64'hA5, 1'b0, -1, 64'd0, 0);
    chk("a5_bits",  st_bits, ord(64'hA5, 8));
    chk("a5_rises", 64'(st_rises), 64'd8);
    chk("a5_busy",  64'(st_busy), 64'd68);
    chk("a5_latch", 64'(st_latch), 64'd4);
    chk("a5_done",  64'(st_done), 64'd1);
    chk("a5_runs",  {32'(st_minrun), 32'(st_maxrun)}, {32'd4, 32'd4});

    // Mid-frame start with new data must be ignored.
    run(0, 64'h0F, 1'b0, 10, 64'hF0, 0);
    chk("ign_bits", st_bits, ord(64'h0F, 8));
    chk("ign_busy", 64'(st_busy), 64'd68);
    chk("ign_done", 64'(st_done), 64'd1);
    quiet = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      quiet += int'(so_a) + int'(sc_a) + int'(sl_a) + int'(bz_a) + int'(dn_a);
    end
    chk("ign_no_second_frame", 64'(quiet), 64'd0);

    // start held high: back-to-back frames every 18 cycles, data resampled.
    run(1, 64'h12, 1'b1, -1, 64'd0, 0);
    chk("hold1_bits", st_bits, ord(64'h12, 8));
    chk("hold1_cyc",  64'(st_cyc), 64'd18);
    chk("hold1_busy", 64'(st_busy), 64'd17);
    run(1, 64'h34, 1'b1, -1, 64'd0, 0);
    chk("hold2_bits", st_bits, ord(64'h34, 8));
    chk("hold2_cyc",  64'(st_cyc), 64'd18);
    run(1, 64'hC1, 1'b1, -1, 64'd0, 0);
    start_b = 1'b0;
    chk("hold3_bits", st_bits, ord(64'hC1, 8));
    chk("hold3_cyc",  64'(st_cyc), 64'd18);
    chk("hold3_done", 64'(st_done), 64'd1);

    // Reset at bit 30 of a 64-bit frame.
    run(2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, -1, 64'd0, 30);
    chk("rst_hit", 64'(st_reset_hit), 64'd1);
    quiet = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      quiet += int'(so_c) + int'(sc_c) + int'(sl_c) + int'(bz_c) + int'(dn_c);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      quiet += int'(so_c) + int'(sc_c) + int'(sl_c) + int'(bz_c) + int'(dn_c);
    end
    chk("rst_no_latch_done", 64'(quiet), 64'd0);
    run(2, 64'h0123_4567_89AB_CDEF, 1'b0, -1, 64'd0, 0);
    chk("post_rst_bits",  st_bits, ord(64'h0123_4567_89AB_CDEF, 64));
    chk("post_rst_rises", 64'(st_rises), 64'd64);
    chk("post_rst_busy",  64'(st_busy), 64'd129);
    chk("post_rst_done",  64'(st_done), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_ser_ctrl.md
SEG_SER_CTRL -- requirements
Module: seg_ser_ctrl

Interface
REQ-001 Parameter DATA_W, default 64: number of segment bits shifted per frame; legal range 2..256.
REQ-002 Parameter DIV, default 4: clk cycles per ser_clk half-period; legal range 1..255.
REQ-003 Port clk  input  1: sole clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1: asynchronous, active-low reset.
REQ-005 Port start  input  1: frame request, sampled on clk edges.
REQ-006 Port data  input  DATA_W: parallel segment pattern, captured when start is accepted.
REQ-007 Port ser_out  output  1: serial data to the external shift register.
REQ-008 Port ser_clk  output  1: shift clock; external shifter samples on its rising edge.
REQ-009 Port ser_latch  output  1: storage-register strobe after the last bit.
REQ-010 Port busy  output  1: frame in progress.
REQ-011 Port done  output  1: one-cycle frame-complete pulse.

Function
REQ-012 The FSM SHALL have states IDLE, LOW, HIGH and LATCH.
REQ-013 In IDLE, start=1 SHALL capture data into a DATA_W shift register, clear the bit counter and the divide counter, and enter LOW on the same edge.
REQ-014 start SHALL be ignored in every state other than IDLE, and captured data SHALL NOT change mid-frame.
REQ-015 In LOW, ser_clk=0 and ser_out=current bit; after DIV cycles the FSM SHALL enter HIGH.
REQ-016 In HIGH, ser_clk=1 and ser_out SHALL be held; after DIV cycles it SHALL shift the register by one.
REQ-017 On leaving HIGH, the FSM SHALL enter LOW if bits sent < DATA_W, else LATCH.
REQ-018 In LATCH, ser_latch=1 and ser_clk=0 for DIV cycles; the FSM SHALL then enter IDLE and assert done for exactly that first IDLE cycle.
REQ-019 Every output SHALL be registered; no output SHALL have a combinational path from start or data.
REQ-020 busy SHALL be 1 in LOW, HIGH and LATCH, and 0 in IDLE.
REQ-021 busy SHALL last exactly 2*DIV*DATA_W + DIV cycles per frame.
REQ-022 Exactly DATA_W ser_clk rising edges SHALL occur per frame.
REQ-023 ser_out SHALL be stable for DIV cycles on each side of every ser_clk rising edge.
REQ-024 In IDLE, ser_out, ser_clk and ser_latch SHALL be 0.
REQ-025 start=1 in the done cycle SHALL be accepted, giving back-to-back frames with one idle cycle between them.
REQ-026 The bit counter SHALL be ceil(log2(DATA_W+1)) bits wide and the divide counter ceil(log2(DIV+1)) bits wide; neither SHALL wrap within a frame.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, with ser_out=0, ser_clk=0, ser_latch=0, busy=0 and done=0, and clear all counters and the shift register.
REQ-028 Reset mid-frame SHALL abort the frame with no ser_latch and no done pulse.
REQ-029 Operation SHALL resume on the first clk edge after rst_n rises, with start sampled normally.

Configuration
REQ-030 Macro SEG_SER_LSB_FIRST_EN SHALL select bit order.
REQ-031 With SEG_SER_LSB_FIRST_EN defined, data[0] SHALL be sent first and data[DATA_W-1] last.
REQ-032 Without SEG_SER_LSB_FIRST_EN, data[DATA_W-1] SHALL be sent first and data[0] last.
REQ-033 All other timing SHALL be identical in both builds.

Verification
REQ-034 DATA_W=64, DIV=1, data=64'h8000_0000_0000_0001, MSB-first build, start for 1 cycle -> bit sequence 1, 62 zeros, 1; 64 ser_clk rises; busy high 129 cycles; ser_latch high 1 cycle; done pulse 1 cycle.
REQ-035 DATA_W=8, DIV=4, data=8'hA5, LSB-first build -> bits 1,0,1,0,0,1,0,1; each ser_clk half-period 4 cycles; busy 68 cycles.
REQ-036 During a frame with data=8'h0F, pulse start with data=8'hF0 -> second request ignored; output stays 8'h0F; a single done pulse.
REQ-037 start held high continuously, DATA_W=8, DIV=1 -> frames repeat every 18 cycles (17 busy + 1 done/IDLE); each frame resamples data.
REQ-038 rst_n low at bit 30 of a 64-bit frame -> all outputs 0 within the same cycle; no ser_latch or done; a fresh start afterwards sends the full 64 bits.
